// File: rtl/mem_arb_pkg.sv
// ============================================================
// Package : mem_arb_pkg
// Shared encodings and helpers for the cache/memory arbiter.
// Rev     : 1.0
// ============================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } arb_state_t;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  // Minimum width able to index n beats; never narrower than one bit.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_picker.sv
// ============================================================
// Module : mem_arb_picker
// Chooses icache or dcache for the next memory transaction.
// ARB_RR_EN defined: round-robin on ties; else dcache priority.
// Rev    : 1.0
// ============================================================
`default_nettype none

module mem_arb_picker
  import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic grant_en,
  input  logic ic_valid,
  input  logic dc_valid,
  output logic grant_ic,
  output logic grant_dc
);

  logic w_win_dc;

`ifdef ARB_RR_EN
  // Pointer names the requester preferred on the next tie.
  logic r_rr_ptr;

  assign w_win_dc = dc_valid && (!ic_valid || (r_rr_ptr == OWN_DC));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr <= OWN_IC;
    end else if (grant_ic) begin
      r_rr_ptr <= OWN_DC;
    end else if (grant_dc) begin
      r_rr_ptr <= OWN_IC;
    end
  end
`else
  assign w_win_dc = dc_valid;
`endif

  assign grant_dc = grant_en && w_win_dc;
  assign grant_ic = grant_en && ic_valid && !w_win_dc;

endmodule

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================
// Module : cache_mem_arbiter
// Shares one memory port between icache refills and dcache
// refills/writebacks, one BEATS-long transaction at a time.
// Build option: ARB_RR_EN selects round-robin arbitration.
// Rev    : 1.0
// ============================================================
`default_nettype none

module cache_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic              ic_resp_last,
  input  logic              dc_req_valid,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  input  logic              dc_wdata_valid,
  output logic              dc_wdata_ready,
  output logic              dc_resp_valid,
  output logic              dc_resp_last,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);

  localparam int               CNT_W       = clog2_w(BEATS);
  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic              r_owner;
  logic [CNT_W-1:0]  r_cnt;

  logic w_grant_en;
  logic w_grant_ic;
  logic w_grant_dc;
  logic w_addr_done;
  logic w_wbeat;
  logic w_rbeat;
  logic w_last;

  mem_arb_picker u_picker (
`ifdef ARB_RR_EN
    .clk      (clk),
    .reset    (reset),
`endif
    .grant_en (w_grant_en),
    .ic_valid (ic_req_valid),
    .dc_valid (dc_req_valid),
    .grant_ic (w_grant_ic),
    .grant_dc (w_grant_dc)
  );

  // Handshakes are masked while reset is low so nothing is accepted on a reset edge.
  assign w_grant_en  = reset && (r_state == IDLE);
  assign w_addr_done = reset && (r_state == ADDR) && mem_req_ready;
  assign w_wbeat     = reset && (r_state == WDATA) && dc_wdata_valid && mem_wdata_ready;
  assign w_rbeat     = reset && (r_state == RDATA) && mem_resp_valid;
  assign w_last      = (r_cnt == C_LAST_BEAT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_ic || w_grant_dc) w_state_nxt = ADDR;
      ADDR:    if (w_addr_done) w_state_nxt = r_rw ? WDATA : RDATA;
      WDATA:   if (w_wbeat && w_last) w_state_nxt = IDLE;
      RDATA:   if (w_rbeat && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_owner <= OWN_IC;
      r_cnt   <= '0;
    end else begin
      if (w_grant_dc) begin
        r_addr  <= dc_req_addr;
        r_rw    <= dc_req_rw;
        r_owner <= OWN_DC;
      end else if (w_grant_ic) begin
        r_addr  <= ic_req_addr;
        r_rw    <= 1'b0;
        r_owner <= OWN_IC;
      end
      if (w_addr_done) begin
        r_cnt <= '0;
      end else if (w_wbeat || w_rbeat) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign ic_req_ready    = w_grant_ic;
  assign dc_req_ready    = w_grant_dc;

  assign mem_req_valid   = reset && (r_state == ADDR);
  assign mem_req_rw      = r_rw;
  assign mem_req_addr    = r_addr;

  // Write beats pass straight through; the dcache is the only possible writer.
  assign mem_wdata       = dc_wdata;
  assign mem_wdata_valid = reset && (r_state == WDATA) && dc_wdata_valid;
  assign dc_wdata_ready  = reset && (r_state == WDATA) && mem_wdata_ready;

  assign ic_resp_valid   = w_rbeat && (r_owner == OWN_IC);
  assign ic_resp_last    = ic_resp_valid && w_last;
  assign dc_resp_valid   = w_rbeat && (r_owner == OWN_DC);
  assign dc_resp_last    = dc_resp_valid && w_last;
  assign resp_data       = mem_resp_data;

  assign busy            = (r_state != IDLE);

endmodule

`default_nettype wire
